// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multiport register file.
package regfile_pkg;

   // Sequencer states: INIT sweeps storage to zero, READY is normal operation.
   typedef enum logic {INIT = 1'b0, READY = 1'b1} state_t;

   // Widest data path the merge helper handles; callers size-cast in and out.
   localparam int MERGE_W  = 1024;
   localparam int MERGE_BE = MERGE_W / 8;

   // Replace each byte of old_v whose enable bit is set with the same byte of new_v.
   function automatic logic [MERGE_W-1:0] byte_merge(input logic [MERGE_W-1:0]  old_v,
                                                     input logic [MERGE_W-1:0]  new_v,
                                                     input logic [MERGE_BE-1:0] be);
      logic [MERGE_W-1:0] r;
      r = old_v;
      for (int b = 0; b < MERGE_BE; b++)
         if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
      return r;
   endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One asynchronous read port: storage mux, range/zero/busy masking and
// optional same-cycle forwarding of an accepted write.
module regfile_read_port
   import regfile_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int DEPTH    = 32,
   parameter int AW       = 5,
   parameter int BYPASS   = 0,
   parameter int ZERO_REG = 1
) (
   input  logic [DEPTH-1:0][WIDTH-1:0] mem,
   input  logic [AW-1:0]               raddr,
   input  logic                        busy,
   input  logic                        we,
   input  logic [AW-1:0]               waddr,
   input  logic [WIDTH-1:0]            wdata,
   input  logic [WIDTH/8-1:0]          be,
   output logic [WIDTH-1:0]            rdata
);

   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

   logic             addr_ok;
   logic             zero_hit;
   logic [WIDTH-1:0] stored;

   assign addr_ok  = ({1'b0, raddr} < DEPTH_W);
   assign zero_hit = (ZERO_REG != 0) && (raddr == '0);

   // Select the entry, overlay a matching in-flight write, then mask invalid reads.
   always_comb begin
      stored = '0;
      if (addr_ok) stored = mem[raddr];
      if ((BYPASS != 0) && we && (waddr == raddr))
         stored = WIDTH'(byte_merge(MERGE_W'(stored), MERGE_W'(wdata), MERGE_BE'(be)));
      rdata = (busy || !addr_ok || zero_hit) ? '0 : stored;
   end

endmodule

// File: rtl/regfile_multiport.sv
// Parametrised register file: NREAD async read ports, one byte-masked write
// port, post-reset sweep that clears one entry per cycle.
module regfile_multiport
   import regfile_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int DEPTH    = 32,
   parameter int NREAD    = 2,
   parameter int BYPASS   = 0,
   parameter int ZERO_REG = 1,
   localparam int AW      = $clog2(DEPTH),
   localparam int NBE     = WIDTH / 8
) (
   input  logic                   Clk,
   input  logic                   Reset,
   input  logic [NREAD*AW-1:0]    ReadRegister,
   output logic [NREAD*WIDTH-1:0] ReadData,
   input  logic [AW-1:0]          WriteRegister,
   input  logic [WIDTH-1:0]       WriteData,
   input  logic [NBE-1:0]         ByteEn,
   input  logic                   RegWrite,
   output logic                   Busy,
   output logic                   WriteIgnored
);

   // Counter is AW+1 bits so a power-of-two DEPTH reaches its last entry without wrapping.
   localparam logic [AW:0] LAST    = (AW+1)'(DEPTH - 1);
   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

   state_t                   state;
   logic [AW:0]              cnt;
   logic [DEPTH-1:0][WIDTH-1:0] mem;
   logic                     busy;
   logic                     waddr_ok;
   logic                     wzero;
   logic                     we;

   assign busy     = Reset || (state == INIT);
   assign waddr_ok = ({1'b0, WriteRegister} < DEPTH_W);
   assign wzero    = (ZERO_REG != 0) && (WriteRegister == '0);
   assign we       = RegWrite && !busy && waddr_ok && !wzero;
   assign Busy     = busy;

   // INIT sequencer: walk the counter over every entry, then park in READY.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state <= INIT;
         cnt   <= '0;
      end else if (state == INIT) begin
         cnt <= cnt + (AW+1)'(1);
         if (cnt == LAST) state <= READY;
      end
   end

   // Storage: sweep clears during INIT, otherwise apply accepted byte-masked writes.
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         if (state == INIT)
            mem[cnt[AW-1:0]] <= '0;
         else if (we)
            mem[WriteRegister] <= WIDTH'(byte_merge(MERGE_W'(mem[WriteRegister]),
                                                    MERGE_W'(WriteData), MERGE_BE'(ByteEn)));
      end
   end

   // One-cycle flag for a write request that was dropped.
   always_ff @(posedge Clk) begin
      if (Reset) WriteIgnored <= 1'b0;
      else       WriteIgnored <= RegWrite && (busy || !waddr_ok || wzero);
   end

   for (genvar i = 0; i < NREAD; i++) begin : g_rd
      regfile_read_port #(
         .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .BYPASS(BYPASS), .ZERO_REG(ZERO_REG)
      ) u_rp (
         .mem   (mem),
         .raddr (ReadRegister[i*AW +: AW]),
         .busy  (busy),
         .we    (we),
         .waddr (WriteRegister),
         .wdata (WriteData),
         .be    (ByteEn),
         .rdata (ReadData[i*WIDTH +: WIDTH])
      );
   end

endmodule
